// File: rtl/ray_dda_stepper.sv
// DDA ray walker over a 16x16 map.
// Queries one cell per step and reports the first wall.
module ray_dda_stepper #(
  parameter int FRAC_BITS = 8,
  parameter int DIST_W    = 16,
  parameter int MAX_STEPS = 32,
  parameter int MAP_LAT   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4+FRAC_BITS-1:0] pos_x,
  input  logic [4+FRAC_BITS-1:0] pos_y,
  input  logic [DIST_W-1:0]      delta_x,
  input  logic [DIST_W-1:0]      delta_y,
  input  logic                   dir_x_neg,
  input  logic                   dir_y_neg,
  input  logic                   is_wall,
  output logic [3:0]             map_x,
  output logic [3:0]             map_y,
  output logic                   is_new_ray,
  output logic                   busy,
  output logic                   done,
  output logic                   hit_valid,
  output logic [3:0]             hit_x,
  output logic [3:0]             hit_y,
  output logic                   hit_side,
  output logic [DIST_W-1:0]      perp_dist
);

  localparam int PW  = 4 + FRAC_BITS;
  localparam int PRW = FRAC_BITS + 1 + DIST_W;
  localparam int CW  = $clog2(MAX_STEPS + 1);
  localparam int LW  = (MAP_LAT > 1) ? $clog2(MAP_LAT) : 1;
  localparam logic [FRAC_BITS:0] ONE = {1'b1, {FRAC_BITS{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_STEP, S_WAIT, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0]     px, py;
  logic [DIST_W-1:0] dx, dy;
  logic              nx, ny;
  logic [3:0]        cx, cy;
  logic [DIST_W-1:0] sx, sy, last_dist;
  logic              side;
  logic [CW-1:0]     step_cnt;
  logic [LW-1:0]     wait_cnt;

  logic [4:0] cx_n, cy_n;
  logic       step_x, leave, max_hit, wait_last;

  function automatic logic [DIST_W-1:0] init_side(
    input logic [FRAC_BITS-1:0] f,
    input logic [DIST_W-1:0]    d,
    input logic                 neg
  );
    logic [FRAC_BITS:0] m;
    logic [PRW-1:0]     p;
    logic [PRW-1:0]     q;
    m = neg ? {1'b0, f} : ONE - {1'b0, f};
    p = PRW'(m) * PRW'(d);
    q = p >> FRAC_BITS;
    if (|q[PRW-1:DIST_W]) return '1;
    return q[DIST_W-1:0];
  endfunction

  function automatic logic [DIST_W-1:0] sat_add(
    input logic [DIST_W-1:0] a,
    input logic [DIST_W-1:0] b
  );
    logic [DIST_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DIST_W] ? '1 : s[DIST_W-1:0];
  endfunction

  // Bit 4 set means the step wrapped out of 0..15.
  assign cx_n = nx ? {1'b0, cx} - 5'd1 : {1'b0, cx} + 5'd1;
  assign cy_n = ny ? {1'b0, cy} - 5'd1 : {1'b0, cy} + 5'd1;
  assign step_x    = (sx <= sy);
  assign leave     = step_x ? cx_n[4] : cy_n[4];
  assign max_hit   = (step_cnt == CW'(MAX_STEPS));
  assign wait_last = (wait_cnt == LW'(MAP_LAT - 1));

  assign done       = (state == S_DONE);
  assign is_new_ray = (state == S_INIT);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_INIT;
      S_INIT: state_nx = S_STEP;
      S_STEP: state_nx = (max_hit || leave) ? S_DONE : S_WAIT;
      S_WAIT: if (wait_last)
                state_nx = is_wall ? S_DONE : S_STEP;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      px <= '0; py <= '0; dx <= '0; dy <= '0;
      nx <= 1'b0; ny <= 1'b0;
      cx <= '0; cy <= '0; sx <= '0; sy <= '0;
      last_dist <= '0; side <= 1'b0;
      step_cnt <= '0; wait_cnt <= '0;
      map_x <= '0; map_y <= '0; busy <= 1'b0;
      hit_valid <= 1'b0; hit_x <= '0; hit_y <= '0;
      hit_side <= 1'b0; perp_dist <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          px <= pos_x; py <= pos_y;
          dx <= delta_x; dy <= delta_y;
          nx <= dir_x_neg; ny <= dir_y_neg;
          busy <= 1'b1;
        end
        S_INIT: begin
          cx <= px[PW-1:FRAC_BITS];
          cy <= py[PW-1:FRAC_BITS];
          sx <= init_side(px[FRAC_BITS-1:0], dx, nx);
          sy <= init_side(py[FRAC_BITS-1:0], dy, ny);
          step_cnt <= '0;
        end
        S_STEP: if (max_hit || leave) begin
          hit_valid <= 1'b0;
          hit_x <= cx; hit_y <= cy; hit_side <= side;
          perp_dist <= '1;
        end else begin
          if (step_x) begin
            last_dist <= sx;
            sx <= sat_add(sx, dx);
            cx <= cx_n[3:0];
            side <= 1'b0;
            map_x <= cx_n[3:0]; map_y <= cy;
          end else begin
            last_dist <= sy;
            sy <= sat_add(sy, dy);
            cy <= cy_n[3:0];
            side <= 1'b1;
            map_x <= cx; map_y <= cy_n[3:0];
          end
          step_cnt <= step_cnt + CW'(1);
          wait_cnt <= '0;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + LW'(1);
          if (wait_last && is_wall) begin
            hit_valid <= 1'b1;
            hit_x <= cx; hit_y <= cy; hit_side <= side;
            perp_dist <= last_dist;
          end
        end
        S_DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
